// File: rtl/resp_tree_pkg.sv
// Shared helpers for the pipelined response fan-in tree: depth, latency and per-node register placement.
// Used by the tree RTL, the request-side tree and the bench so latency is defined in one place.
package resp_tree_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int resp_tree_lat(input int n_slave, input int pipe_every, input int reg_out);
    int l;
    l = clog2_min1(n_slave);
    return ((pipe_every > 0) ? (l - 1) / pipe_every : 0) + reg_out;
  endfunction

  // Heap-numbered node k (root = 1) sits floor(log2 k) levels below the root.
  function automatic int node_level(input int k, input int depth);
    int d;
    d = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= k) d = i;
    end
    return depth - d;
  endfunction

  function automatic bit node_reg(input int level, input int depth, input int pipe_every,
                                  input int reg_out);
    if (level == depth) return reg_out != 0;
    if (pipe_every <= 0) return 1'b0;
    return (level % pipe_every) == 0;
  endfunction

endpackage

// File: rtl/resp_tree_node.sv
// Two-input response fan-in node, lower input wins; optional output register (REG=1 adds 1 cycle).
// No backpressure: the register loads every cycle, data/src only while valid.
module resp_tree_node
  import resp_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = 4,
  parameter int LVL        = 1,
  parameter bit REG        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  v0_i,
  input  logic                  c0_i,
  input  logic [SRC_W-1:0]      src0_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic                  v1_i,
  input  logic                  c1_i,
  input  logic [SRC_W-1:0]      src1_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  v_o,
  output logic                  c_o,
  output logic [SRC_W-1:0]      src_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  typedef struct packed {
    logic                  valid;
    logic                  coll;
    logic [SRC_W-1:0]      src;
    logic [DATA_WIDTH-1:0] data;
  } resp_node_t;

  resp_node_t node_d;

  // Idle nodes drive zeros so an unregistered root reads all-zero when nothing is valid.
  always_comb begin
    node_d             = '0;
    node_d.valid       = v0_i | v1_i;
    node_d.coll        = c0_i | c1_i | (v0_i & v1_i);
    if (v0_i) begin
      node_d.src  = src0_i;
      node_d.data = data0_i;
    end else if (v1_i) begin
      node_d.src  = src1_i;
      node_d.data = data1_i;
    end
    node_d.src[LVL-1]  = v1_i & ~v0_i;
  end

  if (REG) begin : g_reg
    resp_node_t node_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        node_q <= '0;
      end else begin
        node_q.valid <= node_d.valid;
        node_q.coll  <= node_d.coll;
        if (node_d.valid) begin
          node_q.src  <= node_d.src;
          node_q.data <= node_d.data;
        end
      end
    end

    assign {v_o, c_o, src_o, data_o} = node_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign {v_o, c_o, src_o, data_o} = node_d;
  end

endmodule

// File: rtl/resp_tree_pipe.sv
// Pipelined N_SLAVE->1 response tree with source index, collision flag and saturating error counter.
// Latency resp_tree_lat(N_SLAVE, PIPE_EVERY, REG_OUT); no backpressure, one output per accepted input.
module resp_tree_pipe
  import resp_tree_pkg::*;
#(
  parameter int N_SLAVE    = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_EVERY = 2,
  parameter int REG_OUT    = 1,
  parameter int CNT_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_SLAVE-1:0]                   data_r_valid_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   data_r_rdata_i,
  input  logic                                 clr_err_i,
  output logic                                 data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic [clog2_min1(N_SLAVE)-1:0]       data_r_src_o,
  output logic                                 collision_o,
  output logic                                 err_sticky_o,
  output logic [CNT_W-1:0]                     err_cnt_o
);

  localparam int SRC_W = clog2_min1(N_SLAVE);
  localparam int L     = SRC_W;
  localparam int NP    = 1 << L;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Heap layout: node k has children 2k and 2k+1; leaves are NP..2NP-1, root is 1.
  logic [2*NP-1:1]                 t_v;
  logic [2*NP-1:1]                 t_c;
  logic [2*NP-1:1][SRC_W-1:0]      t_src;
  logic [2*NP-1:1][DATA_WIDTH-1:0] t_data;

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < N_SLAVE) begin : g_real
      // Gating with rst keeps inputs sampled during reset out of the tree, also when LAT = 0.
      assign t_v[NP+i]    = data_r_valid_i[i] & ~rst;
      assign t_data[NP+i] = data_r_rdata_i[i];
    end else begin : g_pad
      assign t_v[NP+i]    = 1'b0;
      assign t_data[NP+i] = '0;
    end
    assign t_c[NP+i]   = 1'b0;
    assign t_src[NP+i] = '0;
  end

  for (genvar k = 1; k < NP; k++) begin : g_node
    localparam int LV = node_level(k, L);
    localparam bit RG = node_reg(LV, L, PIPE_EVERY, REG_OUT);

    resp_tree_node #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRC_W      (SRC_W),
      .LVL        (LV),
      .REG        (RG)
    ) u_node (
      .clk     (clk),
      .rst     (rst),
      .v0_i    (t_v[2*k]),
      .c0_i    (t_c[2*k]),
      .src0_i  (t_src[2*k]),
      .data0_i (t_data[2*k]),
      .v1_i    (t_v[2*k+1]),
      .c1_i    (t_c[2*k+1]),
      .src1_i  (t_src[2*k+1]),
      .data1_i (t_data[2*k+1]),
      .v_o     (t_v[k]),
      .c_o     (t_c[k]),
      .src_o   (t_src[k]),
      .data_o  (t_data[k])
    );
  end

  assign data_r_valid_o = t_v[1];
  assign data_r_rdata_o = t_data[1];
  assign data_r_src_o   = t_src[1];
  assign collision_o    = t_c[1];

  logic             err_sticky_d, err_sticky_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  // A clear in the same cycle as a collision wins and that collision is not counted.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (clr_err_i) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (collision_o) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign err_sticky_o = err_sticky_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_resp_tree_pipe.sv
// Scoreboard bench: a 5-slave pipelined tree (LAT=3, 2-bit counter) and a 16-slave combinational tree.
module tb_resp_tree_pipe;

  localparam int LAT_A = 3;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    int          src;
    logic        coll;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: N_SLAVE=5, PIPE_EVERY=1, REG_OUT=1, CNT_W=2
  logic [4:0]       va = '0;
  logic [4:0][31:0] da = '0;
  logic             clr_a = 1'b0;
  logic             a_vld, a_coll, a_sticky;
  logic [31:0]      a_data;
  logic [2:0]       a_src;
  logic [1:0]       a_cnt;

  // DUT B: N_SLAVE=16, PIPE_EVERY=0, REG_OUT=0, CNT_W=8
  logic [15:0]       vb = '0;
  logic [15:0][31:0] db = '0;
  logic              b_vld, b_coll, b_sticky;
  logic [31:0]       b_data;
  logic [3:0]        b_src;
  logic [7:0]        b_cnt;

  resp_tree_pipe #(.N_SLAVE(5), .DATA_WIDTH(32), .PIPE_EVERY(1), .REG_OUT(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .data_r_valid_i(va), .data_r_rdata_i(da), .clr_err_i(clr_a),
    .data_r_valid_o(a_vld), .data_r_rdata_o(a_data), .data_r_src_o(a_src),
    .collision_o(a_coll), .err_sticky_o(a_sticky), .err_cnt_o(a_cnt)
  );

  resp_tree_pipe #(.N_SLAVE(16), .DATA_WIDTH(32), .PIPE_EVERY(0), .REG_OUT(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .data_r_valid_i(vb), .data_r_rdata_i(db), .clr_err_i(1'b0),
    .data_r_valid_o(b_vld), .data_r_rdata_o(b_data), .data_r_src_o(b_src),
    .collision_o(b_coll), .err_sticky_o(b_sticky), .err_cnt_o(b_cnt)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic [15:0] mh_vec [6] = '{16'h0006, 16'h8001, 16'hC000, 16'hFFFF, 16'h0A00, 16'h1010};
  int          mh_idx [6] = '{1, 0, 14, 0, 9, 4};
  int          cnt_seq [5] = '{1, 2, 3, 3, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_at(input int n);
    goto(n);
    @(negedge clk);
  endtask

  task automatic send_a(input logic [4:0] v, input logic [31:0] d, input int src, input logic coll);
    va = v;
    qa.push_back('{cyc: cyc + LAT_A, data: d, src: src, coll: coll});
  endtask

  task automatic send_b(input logic [15:0] v, input int src, input logic coll);
    for (int j = 0; j < 16; j++) db[j] = $urandom;
    vb = v;
    qb.push_back('{cyc: cyc, data: db[src], src: src, coll: coll});
  endtask

  always @(negedge clk) begin
    if (a_vld) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_valid at cycle %0d: got valid=1, required 0", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_out_cycle", 64'(cyc), 64'(ea.cyc));
        chk("a_rdata", 64'(a_data), 64'(ea.data));
        chk("a_src", 64'(a_src), 64'(ea.src));
        chk("a_collision", 64'(a_coll), 64'(ea.coll));
      end
    end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
      ea = qa.pop_front();
      checks++; failures++;
      $display("FAIL a_missing_valid at cycle %0d: got valid=0, required 1 for src %0d", cyc, ea.src);
    end
    if (!a_vld && a_coll) begin
      checks++; failures++;
      $display("FAIL a_coll_without_valid at cycle %0d: got collision=1, required 0", cyc);
    end
  end

  always @(negedge clk) begin
    if (b_vld) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_valid at cycle %0d: got valid=1, required 0", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_out_cycle", 64'(cyc), 64'(eb.cyc));
        chk("b_rdata", 64'(b_data), 64'(eb.data));
        chk("b_src", 64'(b_src), 64'(eb.src));
        chk("b_collision", 64'(b_coll), 64'(eb.coll));
      end
    end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
      eb = qb.pop_front();
      checks++; failures++;
      $display("FAIL b_missing_valid at cycle %0d: got valid=0, required 1 for src %0d", cyc, eb.src);
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) da[i] = 32'h100 + 32'(i);
    goto(3);
    rst = 1'b0;

    // Reset state
    chk_at(4);
    chk("rst_a_valid", 64'(a_vld), 64'd0);
    chk("rst_a_rdata", 64'(a_data), 64'd0);
    chk("rst_a_src", 64'(a_src), 64'd0);
    chk("rst_a_sticky", 64'(a_sticky), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_b_valid", 64'(b_vld), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);

    // Single response from the highest slave
    goto(10);
    da[4] = 32'hCAFE0004;
    send_a(5'b10000, 32'hCAFE0004, 4, 1'b0);
    goto(11);
    va = '0;
    da[4] = 32'h104;

    // Back-to-back responses from every slave
    for (int i = 0; i < 5; i++) begin
      goto(20 + i);
      send_a(5'(1 << i), 32'h100 + 32'(i), i, 1'b0);
    end
    goto(25);
    va = '0;

    // Collision of slaves 1 and 3
    goto(30);
    send_a(5'b01010, 32'h101, 1, 1'b1);
    goto(31);
    va = '0;
    chk_at(33);
    chk("coll_cnt_before", 64'(a_cnt), 64'd0);
    chk("coll_sticky_before", 64'(a_sticky), 64'd0);
    chk_at(34);
    chk("coll_sticky_after", 64'(a_sticky), 64'd1);
    chk("coll_cnt_after", 64'(a_cnt), 64'd1);

    // Reset with a response in flight
    goto(40);
    va = 5'b00100;
    goto(41);
    va = '0;
    rst = 1'b1;
    goto(42);
    rst = 1'b0;
    @(negedge clk);
    chk("inflight_rst_valid", 64'(a_vld), 64'd0);
    chk("inflight_rst_rdata", 64'(a_data), 64'd0);
    chk("inflight_rst_src", 64'(a_src), 64'd0);
    chk("inflight_rst_coll", 64'(a_coll), 64'd0);
    chk("inflight_rst_sticky", 64'(a_sticky), 64'd0);
    chk("inflight_rst_cnt", 64'(a_cnt), 64'd0);
    chk_at(43);
    chk("inflight_rst_valid_43", 64'(a_vld), 64'd0);

    // Saturation of the 2-bit counter
    for (int t = 50; t <= 58; t++) begin
      goto(t);
      if (t < 55) send_a(5'b00011, 32'h100, 0, 1'b1);
      else va = '0;
      if (t >= 54) begin
        @(negedge clk);
        chk("sat_cnt", 64'(a_cnt), 64'(cnt_seq[t-54]));
        chk("sat_sticky", 64'(a_sticky), 64'd1);
      end
    end

    // Clear coinciding with a collision
    goto(60);
    send_a(5'b00011, 32'h100, 0, 1'b1);
    goto(61);
    va = '0;
    goto(63);
    clr_a = 1'b1;
    @(negedge clk);
    chk("clr_cnt_before", 64'(a_cnt), 64'd3);
    goto(64);
    clr_a = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 64'(a_cnt), 64'd0);
    chk("clr_sticky", 64'(a_sticky), 64'd0);
    chk_at(66);
    chk("clr_cnt_hold", 64'(a_cnt), 64'd0);

    // Combinational 16-slave tree: one-hot then multi-hot traffic
    for (int n = 0; n < 20; n++) begin
      int idx;
      goto(70 + n);
      idx = $urandom_range(0, 15);
      send_b(16'(1 << idx), idx, 1'b0);
    end
    for (int n = 0; n < 6; n++) begin
      goto(90 + n);
      send_b(mh_vec[n], mh_idx[n], 1'b1);
    end
    goto(96);
    vb = '0;
    chk_at(97);
    chk("b_cnt", 64'(b_cnt), 64'd6);
    chk("b_sticky", 64'(b_sticky), 64'd1);

    chk_at(105);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resp_tree_pipe.md
Name: resp_tree_pipe

Overview:
- Parametrised, pipelined successor of the logarithmic-interconnect response tree.
- Routes one-hot response traffic from N_SLAVE memory banks or slaves back to a single master port.
- Supports any N_SLAVE ≥ 2 (not only powers of two) and places a configurable number of pipeline registers inside the binary fan-in tree.
- Reports the source index of each response, detects protocol violations (more than one valid input in the same cycle) and keeps a saturating error counter for the cluster debug unit.

Parameters:
- N_SLAVE, 16: number of response inputs; must be ≥ 2.
- DATA_WIDTH, 32: response data width.
- PIPE_EVERY, 2: insert a register stage after every PIPE_EVERY tree levels; 0 = fully combinational tree.
- REG_OUT, 1: 1 = register the outputs after the root node.
- CNT_W, 8: width of the collision counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_r_valid_i  in  N_SLAVE  per-slave response valid.
- data_r_rdata_i  in  N_SLAVE x DATA_WIDTH  per-slave response data.
- clr_err_i  in  1  clears err_cnt_o and err_sticky_o.
- data_r_valid_o  out  1  response valid towards the master.
- data_r_rdata_o  out  DATA_WIDTH  response data.
- data_r_src_o  out  SRC_W = max(1, clog2(N_SLAVE))  index of the slave that produced the response.
- collision_o  out  1  pulse, aligned with data_r_valid_o: two or more inputs were valid in the source cycle.
- err_sticky_o  out  1  set by any collision; held until clr_err_i or rst.
- err_cnt_o  out  CNT_W  saturating count of collision events.

Behaviour:
- Tree structure:
  - Tree depth L = clog2(N_SLAVE). Levels are numbered 1 (leaf) to L (root).
  - Inputs are padded to 2^L; padded inputs are tied to valid=0, data=0.
- Node function, combinational:
  - valid = v0 | v1.
  - If v0 is set, select data0/src0 with src MSB appended 0; else select data1/src1 with MSB 1. Lower index wins.
  - coll = coll0 | coll1 | (v0 & v1).
- Pipeline registers:
  - A register stage follows level l when PIPE_EVERY > 0, l mod PIPE_EVERY = 0 and l < L.
  - If REG_OUT = 1, a register also follows the root.
  - Latency LAT = (PIPE_EVERY > 0 ? floor((L-1)/PIPE_EVERY) : 0) + REG_OUT cycles, input to output. LAT = 0 is legal and makes the block purely combinational except for the error logic.
- No backpressure:
  - Every valid input produces exactly one valid output LAT cycles later.
  - Pipeline registers load every cycle; data/src registers load only when their valid is set, which saves power. Held data is don't-care while valid = 0.
- Collision:
  - The lower-index response is delivered; higher-index responses in the same cycle are dropped.
  - collision_o is asserted on the same output cycle as that delivered response.
- Error logic is registered and runs on the output-side collision_o:
  - err_sticky_o: set 1 cycle after collision_o is high.
  - err_cnt_o: increments 1 cycle after each collision_o cycle and saturates at 2^CNT_W − 1.
  - If clr_err_i and collision_o are high in the same cycle, clear wins: counter → 0, sticky → 0. The collision in that cycle is not counted.
- Reset:
  - Clears all pipeline valid and collision bits, data/src registers, err_sticky_o and err_cnt_o to 0.
  - All outputs read 0 in the cycle after rst is sampled high.
  - Responses in flight during reset are discarded, not replayed.
  - Inputs sampled while rst is high are ignored.
- Back-to-back responses from different slaves on consecutive cycles appear on consecutive output cycles in the same order, with no bubbles.

Decomposition:
- Package resp_tree_pkg:
  - Function clog2_min1.
  - Function resp_tree_lat(N_SLAVE, PIPE_EVERY, REG_OUT), shared with the bench and the request-side tree.
  - Typedef resp_node_t (valid, coll, src, data) as a parameterised struct, or field offsets if tools lack parameterised types.
- Sub-module resp_tree_node:
  - One two-input fan-in node with a parameter REG (0/1) selecting an optional output register with synchronous reset.
  - The top level generates the tree from resp_tree_node instances and adds the error counter.

Test Plan:
1. N_SLAVE=5, PIPE_EVERY=1, REG_OUT=1 (L=3, LAT=3): data_r_valid_i=5'b10000, rdata[4]=0xCAFE0004 at cycle 10 → cycle 13: valid_o=1, rdata_o=0xCAFE0004, src_o=4, collision_o=0.
2. Same configuration, slaves 0,1,2,3,4 valid on cycles 20..24 with rdata=0x100+i → valid_o high on cycles 23..27, src_o=0..4 in order, no gaps.
3. Same configuration, valid_i=5'b01010 at cycle 30 → cycle 33: rdata_o=rdata[1], src_o=1, collision_o=1; err_sticky_o=1 and err_cnt_o=1 from cycle 34.
4. CNT_W=2, 5 collision cycles → err_cnt_o goes 1,2,3,3,3. Then clr_err_i pulsed with a simultaneous collision → err_cnt_o=0, err_sticky_o=0.
5. Slave 2 valid at cycle 40, rst high at cycle 41 (LAT=3) → no valid_o on cycles 42..43; all outputs 0 after reset.
6. N_SLAVE=16, PIPE_EVERY=0, REG_OUT=0 (LAT=0): random one-hot traffic → outputs match the inputs in the same cycle, src_o equals the one-hot index; random multi-hot traffic → lowest index selected, collision_o=1.
